// File: rtl/fc_spk_ram_sched_pkg.sv
// Shared types and helpers for the fully-connected layer spike-RAM scheduler.
package fc_spk_ram_sched_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } sched_state_t;

   // Spike RAM words are laid out time-step major, input channel minor.
   function automatic int addr_of(input int time_step, input int ic, input int input_channels = 2);
      return time_step * input_channels + ic;
   endfunction

endpackage

// File: rtl/fc_spk_ram_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_EC = 4,
   parameter int IDX_W  = (NUM_EC > 1) ? $clog2(NUM_EC) : 1
) (
   input  logic [NUM_EC-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [NUM_EC-1:0] gnt,
   output logic [IDX_W-1:0]  gnt_idx
);

   logic             found;
   logic [IDX_W-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 0; k < NUM_EC; k++) begin
         idx = IDX_W'((int'(ptr) + k) % NUM_EC);
         if (!found && req[idx]) begin
            found        = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = idx;
         end
      end
   end

endmodule

// File: rtl/fc_spk_ram_sched.sv
// Layer scheduler: starts the engines, shares the spike RAM read port round-robin,
// and signals layer completion once every engine reports done.
module fc_spk_ram_sched
   import fc_spk_ram_sched_pkg::*;
#(
   parameter int NUM_EC           = 4,
   parameter int TIME_STEPS       = 10,
   parameter int INPUT_CHANNELS   = 2,
   parameter int INPUT_FRAME_SIZE = 120,
   parameter int ADDR_W           = $clog2(TIME_STEPS * INPUT_CHANNELS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        pre_syn_RAM_loaded,
   output logic                        eng_start,
   input  logic [NUM_EC-1:0]           req_en,
   input  logic [NUM_EC*ADDR_W-1:0]    req_addr,
   output logic [NUM_EC-1:0]           gnt,
   output logic                        ram_en,
   output logic [ADDR_W-1:0]           ram_addr,
   input  logic [INPUT_FRAME_SIZE-1:0] ram_rdata,
   output logic [INPUT_FRAME_SIZE-1:0] rd_data,
   output logic [NUM_EC-1:0]           rd_valid,
   input  logic [NUM_EC-1:0]           eng_done,
   output logic                        post_syn_RAM_loaded,
   output logic [CNT_W-1:0]            grant_cnt,
   output logic [CNT_W-1:0]            conflict_cnt
);

   localparam int IDX_W = (NUM_EC > 1) ? $clog2(NUM_EC) : 1;

   sched_state_t      state_q, state_d;
   logic              pre_q, pre_d;
   logic [NUM_EC-1:0] done_mask_q, done_mask_d;
   logic [NUM_EC-1:0] rd_valid_q, rd_valid_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              post_q, post_d;
   logic [CNT_W-1:0]  grant_cnt_q, grant_cnt_d;
   logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

   logic [NUM_EC-1:0] arb_gnt;
   logic [IDX_W-1:0]  arb_idx;
   logic              pre_rise;
   logic              multi_req;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   rr_arbiter #(
      .NUM_EC (NUM_EC),
      .IDX_W  (IDX_W)
   ) u_arb (
      .req     (req_en),
      .ptr     (rr_ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   assign pre_rise  = pre_syn_RAM_loaded & ~pre_q;
   assign multi_req = ($countones(req_en) >= 2);

   always_comb begin
      state_d        = state_q;
      pre_d          = pre_syn_RAM_loaded;
      done_mask_d    = done_mask_q;
      rr_ptr_d       = rr_ptr_q;
      post_d         = post_q;
      grant_cnt_d    = grant_cnt_q;
      conflict_cnt_d = conflict_cnt_q;
      gnt            = '0;
      ram_en         = 1'b0;
      ram_addr       = '0;
      eng_start      = 1'b0;
      rd_valid_d     = '0;

      case (state_q)
         IDLE, DONE: begin
            if (pre_rise) state_d = START;
         end
         START: begin
            eng_start      = 1'b1;
            done_mask_d    = '0;
            grant_cnt_d    = '0;
            conflict_cnt_d = '0;
            post_d         = 1'b0;
            rr_ptr_d       = '0;
            state_d        = RUN;
         end
         RUN: begin
            gnt      = arb_gnt;
            ram_en   = |req_en;
            ram_addr = ADDR_W'(req_addr >> (int'(arb_idx) * ADDR_W));
            if (ram_en) begin
               rr_ptr_d    = (arb_idx == IDX_W'(NUM_EC - 1)) ? '0 : arb_idx + IDX_W'(1);
               grant_cnt_d = sat_inc(grant_cnt_q);
            end
            if (multi_req) conflict_cnt_d = sat_inc(conflict_cnt_q);
            // This cycle's grant is still issued even if it completes the mask.
            done_mask_d = done_mask_q | eng_done;
            if (&done_mask_d) state_d = DRAIN;
         end
         DRAIN: begin
            post_d  = 1'b1;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         gnt       = '0;
         ram_en    = 1'b0;
         eng_start = 1'b0;
      end
      rd_valid_d = gnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         pre_q          <= 1'b0;
         done_mask_q    <= '0;
         rd_valid_q     <= '0;
         rr_ptr_q       <= '0;
         post_q         <= 1'b0;
         grant_cnt_q    <= '0;
         conflict_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         pre_q          <= pre_d;
         done_mask_q    <= done_mask_d;
         rd_valid_q     <= rd_valid_d;
         rr_ptr_q       <= rr_ptr_d;
         post_q         <= post_d;
         grant_cnt_q    <= grant_cnt_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign rd_data             = ram_rdata;
   assign rd_valid            = rd_valid_q;
   assign post_syn_RAM_loaded = post_q;
   assign grant_cnt           = grant_cnt_q;
   assign conflict_cnt        = conflict_cnt_q;

endmodule

// File: tb/tb_fc_spk_ram_sched.sv
// Bench for fc_spk_ram_sched: directed layer sequences with random requests/data,
// checked against a behavioural round-robin scheduling model.
module tb_fc_spk_ram_sched;
   import fc_spk_ram_sched_pkg::*;

   localparam int NUM_EC = 4;
   localparam int TS     = 10;
   localparam int IC     = 2;
   localparam int FS     = 120;
   localparam int ADDR_W = $clog2(TS * IC);

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     pre = 1'b0;
   logic                     eng_start;
   logic [NUM_EC-1:0]        req_en = '0;
   logic [NUM_EC*ADDR_W-1:0] req_addr;
   logic [NUM_EC-1:0]        gnt;
   logic                     ram_en;
   logic [ADDR_W-1:0]        ram_addr;
   logic [FS-1:0]            ram_rdata = '0;
   logic [FS-1:0]            rd_data;
   logic [NUM_EC-1:0]        rd_valid;
   logic [NUM_EC-1:0]        eng_done = '0;
   logic                     post;
   logic [CNT_W-1:0]         grant_cnt;
   logic [CNT_W-1:0]         conflict_cnt;

   logic [ADDR_W-1:0] addr_tab [NUM_EC];
   assign req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};

   fc_spk_ram_sched #(
      .NUM_EC           (NUM_EC),
      .TIME_STEPS       (TS),
      .INPUT_CHANNELS   (IC),
      .INPUT_FRAME_SIZE (FS),
      .ADDR_W           (ADDR_W)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .pre_syn_RAM_loaded  (pre),
      .eng_start           (eng_start),
      .req_en              (req_en),
      .req_addr            (req_addr),
      .gnt                 (gnt),
      .ram_en              (ram_en),
      .ram_addr            (ram_addr),
      .ram_rdata           (ram_rdata),
      .rd_data             (rd_data),
      .rd_valid            (rd_valid),
      .eng_done            (eng_done),
      .post_syn_RAM_loaded (post),
      .grant_cnt           (grant_cnt),
      .conflict_cnt        (conflict_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model of the layer, tracked per cycle
   bit                m_run;
   int                m_ptr;
   int                m_gcnt;
   int                m_ccnt;
   bit                m_post;
   int                m_post_delay;
   logic [NUM_EC-1:0] m_done_seen;
   logic [NUM_EC-1:0] m_prev_gnt;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_idle();
      m_run = 1'b0; m_ptr = 0; m_gcnt = 0; m_ccnt = 0;
      m_post = 1'b0; m_post_delay = 0; m_done_seen = '0; m_prev_gnt = '0;
   endtask

   task automatic model_layer_start();
      model_idle();
      m_run = 1'b1;
   endtask

   task automatic run_cycle(input logic [NUM_EC-1:0] req, input logic [NUM_EC-1:0] done, input bit rnd);
      logic [NUM_EC-1:0] exp_gnt;
      logic [ADDR_W-1:0] exp_addr;
      logic [127:0]      wide;
      logic [1:0]        j;
      int                win;
      req_en   = req;
      eng_done = done;
      if (rnd) begin
         for (int i = 0; i < NUM_EC; i++) begin
            j = 2'(i);
            addr_tab[j] = ADDR_W'(addr_of(int'($urandom_range(0, TS - 1)), int'($urandom_range(0, IC - 1)), IC));
         end
         wide      = {$urandom(), $urandom(), $urandom(), $urandom()};
         ram_rdata = wide[FS-1:0];
      end
      exp_gnt  = '0;
      exp_addr = '0;
      win      = -1;
      if (m_run) begin
         for (int k = 0; k < NUM_EC; k++) begin
            j = 2'((m_ptr + k) % NUM_EC);
            if (win < 0 && req[j]) begin
               win        = int'(j);
               exp_gnt[j] = 1'b1;
               exp_addr   = addr_tab[j];
            end
         end
      end
      @(negedge clk);
      chk("gnt", 128'(gnt), 128'(exp_gnt));
      chk("ram_en", 128'(ram_en), 128'(|exp_gnt));
      if (exp_gnt != '0) chk("ram_addr", 128'(ram_addr), 128'(exp_addr));
      chk("rd_valid", 128'(rd_valid), 128'(m_prev_gnt));
      if (m_prev_gnt != '0) chk("rd_data", 128'(rd_data), 128'(ram_rdata));
      chk("eng_start_low", 128'(eng_start), 128'(0));
      chk("post", 128'(post), 128'(m_post));
      chk("grant_cnt", 128'(grant_cnt), 128'(m_gcnt));
      chk("conflict_cnt", 128'(conflict_cnt), 128'(m_ccnt));
      @(posedge clk); #1;
      m_prev_gnt = exp_gnt;
      if (m_post_delay > 0) begin
         m_post_delay--;
         if (m_post_delay == 0) m_post = 1'b1;
      end
      if (m_run) begin
         if (win >= 0) begin
            m_gcnt++;
            m_ptr = (win + 1) % NUM_EC;
         end
         if ($countones(req) >= 2) m_ccnt++;
         m_done_seen |= done;
         if (&m_done_seen) begin
            m_run        = 1'b0;
            m_post_delay = 1;
         end
      end
   endtask

   task automatic start_layer();
      pre = 1'b0; req_en = '0; eng_done = '0;
      @(posedge clk); #1;
      pre = 1'b1; req_en = 4'hF;
      @(negedge clk);
      chk("start_edge_eng_start", 128'(eng_start), 128'(0));
      chk("start_edge_gnt", 128'(gnt), 128'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("eng_start_pulse", 128'(eng_start), 128'(1));
      chk("start_gnt", 128'(gnt), 128'(0));
      @(posedge clk); #1;
      model_layer_start();
   endtask

   initial begin
      for (int i = 0; i < NUM_EC; i++) addr_tab[i] = '0;
      model_idle();

      // Reset values, with requests present that must not be granted
      rst = 1'b1; req_en = 4'hF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", 128'(gnt), 128'(0));
      chk("rst_ram_en", 128'(ram_en), 128'(0));
      chk("rst_rd_valid", 128'(rd_valid), 128'(0));
      chk("rst_eng_start", 128'(eng_start), 128'(0));
      chk("rst_post", 128'(post), 128'(0));
      chk("rst_grant_cnt", 128'(grant_cnt), 128'(0));
      chk("rst_conflict_cnt", 128'(conflict_cnt), 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      run_cycle(4'hF, 4'h0, 1'b1);

      // Layer 1: all engines requesting for eight cycles
      start_layer();
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < NUM_EC; i++) addr_tab[i] = ADDR_W'(i);
         run_cycle(4'hF, 4'h0, 1'b0);
      end
      chk("t2_grant_cnt", 128'(grant_cnt), 128'(8));
      chk("t2_conflict_cnt", 128'(conflict_cnt), 128'(8));

      // Single requester: engine 2, address 5
      req_en = 4'b0100; eng_done = '0; addr_tab[2] = ADDR_W'(5);
      @(negedge clk);
      chk("t3_gnt", 128'(gnt), 128'(4'b0100));
      chk("t3_ram_addr", 128'(ram_addr), 128'(5));
      chk("t3_rd_valid_prev", 128'(rd_valid), 128'(m_prev_gnt));
      @(posedge clk); #1;
      req_en = '0; ram_rdata = FS'(12'hABC);
      @(negedge clk);
      chk("t3_rd_valid", 128'(rd_valid), 128'(4'b0100));
      chk("t3_rd_data", 128'(rd_data), 128'(12'hABC));
      @(posedge clk); #1;
      m_gcnt += 1; m_ptr = 3; m_prev_gnt = '0;
      run_cycle(4'hF, 4'h0, 1'b1);

      // Random traffic, then staggered completion
      for (int c = 1; c <= 40; c++)
         run_cycle(4'($urandom_range(0, 15)),
                   {c >= 40 ? 1'b1 : 1'b0, c >= 30 ? 1'b1 : 1'b0, c >= 20 ? 1'b1 : 1'b0, c >= 10 ? 1'b1 : 1'b0},
                   1'b1);
      for (int c = 0; c < 4; c++) run_cycle(4'($urandom_range(0, 15)), 4'hF, 1'b1);
      chk("t4_post_held", 128'(post), 128'(1));

      // Level held high across DONE must not restart the layer
      for (int c = 0; c < 3; c++) run_cycle(4'hF, 4'h0, 1'b1);

      // Layer 2: fresh start with cleared counters, then reset mid-run
      start_layer();
      for (int c = 0; c < 6; c++) run_cycle(4'($urandom_range(1, 15)), 4'h0, 1'b1);
      pre = 1'b0; rst = 1'b1; req_en = 4'hF;
      @(negedge clk);
      chk("t5_rst_gnt", 128'(gnt), 128'(0));
      chk("t5_rst_ram_en", 128'(ram_en), 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_rd_valid", 128'(rd_valid), 128'(0));
      chk("t5_post", 128'(post), 128'(0));
      chk("t5_grant_cnt", 128'(grant_cnt), 128'(0));
      chk("t5_conflict_cnt", 128'(conflict_cnt), 128'(0));
      chk("t5_idle_gnt", 128'(gnt), 128'(0));
      @(posedge clk); #1;
      model_idle();
      run_cycle(4'hF, 4'h0, 1'b1);

      // Layer 3: short random layer run to completion
      start_layer();
      for (int c = 0; c < 12; c++) run_cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
      for (int c = 0; c < 4; c++) run_cycle(4'($urandom_range(0, 15)), 4'hF, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
